// File: rtl/ball_pkg.sv
// Shared types and screen geometry for the ball animation slice.
package ball_pkg;

  localparam int unsigned BALL_SIZE = 4;
  localparam int unsigned SCREEN_W  = 160;
  localparam int unsigned SCREEN_H  = 120;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAW  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ERASE = 3'd3,
    ST_CHECK = 3'd4,
    ST_MOVE  = 3'd5
  } ball_state_t;

endpackage

// File: rtl/ball_frame_timer.sv
// Frame delay counter: counts 0..FRAME_TICKS-1 while start is held high,
// asserting done on the last count.
module ball_frame_timer
  import ball_pkg::*;
#(
  parameter int unsigned FRAME_TICKS = 833333
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic done
);

  localparam int unsigned   CW   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_TICKS - 1);

  logic [CW-1:0] count;

  assign done = start && (count == LAST);

  // start stays high for the whole wait interval; dropping it rearms the count.
  always_ff @(posedge clock) begin
    if (reset || !start || done) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ball_control.sv
// Ball animation sequencer: draw, frame wait, erase, collision check, move.
// Optional paddle collision / ball-loss detection enabled by BALL_PADDLE_EN.
module ball_control
  import ball_pkg::*;
#(
  parameter int unsigned FRAME_TICKS = 833333,
  parameter int unsigned X_MAX       = 156,
  parameter int unsigned Y_MIN       = 0,
  parameter int unsigned Y_MAX       = 116,
  parameter int unsigned PADDLE_Y    = 112,
  parameter int unsigned PADDLE_W    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic       h_q,
  input  logic       v_q,
  input  logic [7:0] paddle_x,
  output logic       reset_counts,
  output logic       en_counters,
  output logic       sel_c,
  output logic       h_t,
  output logic       v_t,
  output logic       plot,
  output logic [1:0] off_x,
  output logic [1:0] off_y,
  output logic       lost
);

  localparam logic [8:0] X_MAX9 = 9'(X_MAX);
  localparam logic [8:0] Y_MIN9 = 9'(Y_MIN);
  localparam logic [8:0] Y_MAX9 = 9'(Y_MAX);

  ball_state_t state, state_next;
  logic [3:0]  p;
  logic        in_wait;
  logic        frame_done;

  logic [8:0]  x9, y9;
  logic        h_hit, v_hit, bottom_hit, loss;

  assign in_wait = (state == ST_WAIT);

  ball_frame_timer #(
    .FRAME_TICKS(FRAME_TICKS)
  ) u_frame_timer (
    .clock(clock),
    .reset(reset),
    .start(in_wait),
    .done (frame_done)
  );

  assign x9 = {1'b0, x};
  assign y9 = {2'b0, y};

  assign h_hit = (h_q && (x9 >= X_MAX9)) || (!h_q && (x9 == '0));

`ifdef BALL_PADDLE_EN
  localparam logic [8:0] PADDLE_Y9 = 9'(PADDLE_Y);
  localparam logic [8:0] PADDLE_W9 = 9'(PADDLE_W);
  logic [8:0] px9;
  assign px9 = {1'b0, paddle_x};

  // Any ball column overlapping the paddle span counts as a hit.
  assign bottom_hit = v_q && ((y9 + 9'(BALL_SIZE)) == PADDLE_Y9)
                          && ((x9 + 9'(BALL_SIZE - 1)) >= px9)
                          && (x9 <= (px9 + PADDLE_W9 - 9'd1));
  assign loss       = v_q && (y9 >= Y_MAX9);
`else
  logic unused_paddle;
  assign unused_paddle = ^paddle_x;
  assign bottom_hit    = v_q && (y9 >= Y_MAX9);
  assign loss          = 1'b0;
`endif

  assign v_hit = (!v_q && (y9 <= Y_MIN9)) || bottom_hit;

  always_comb begin
    state_next   = state;
    reset_counts = 1'b1;
    en_counters  = 1'b0;
    sel_c        = 1'b0;
    h_t          = 1'b0;
    v_t          = 1'b0;
    plot         = 1'b0;
    off_x        = '0;
    off_y        = '0;
    lost         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        reset_counts = 1'b0;
        if (go) state_next = ST_DRAW;
      end
      ST_DRAW: begin
        plot  = 1'b1;
        sel_c = 1'b1;
        off_x = p[1:0];
        off_y = p[3:2];
        if (p == 4'd15) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (frame_done) state_next = ST_ERASE;
      end
      ST_ERASE: begin
        plot  = 1'b1;
        off_x = p[1:0];
        off_y = p[3:2];
        if (p == 4'd15) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (loss) begin
          lost       = 1'b1;
          state_next = ST_IDLE;
        end else begin
          h_t        = h_hit;
          v_t        = v_hit;
          state_next = ST_MOVE;
        end
      end
      ST_MOVE: begin
        en_counters = 1'b1;
        state_next  = ST_DRAW;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // p wraps from 15 to 0 on the DRAW/ERASE exit edge, so it is always clear on entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      p     <= '0;
    end else begin
      state <= state_next;
      if ((state == ST_DRAW) || (state == ST_ERASE)) begin
        p <= p + 4'd1;
      end else begin
        p <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ball_control.sv
// Scoreboard bench for ball_control: per-cycle expected outputs are queued by
// the stimulus process and compared by a monitor on the falling edge.
module tb_ball_control;

  logic       clock = 1'b0;
  logic       reset;
  logic       go;
  logic [7:0] x;
  logic [6:0] y;
  logic       h_q, v_q;
  logic [7:0] paddle_x;
  logic       reset_counts, en_counters, sel_c, h_t, v_t, plot, lost;
  logic [1:0] off_x, off_y;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [10:0] v;
    string       n;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock = ~clock;

  ball_control #(
    .FRAME_TICKS(4),
    .X_MAX      (156),
    .Y_MIN      (0),
    .Y_MAX      (116),
    .PADDLE_Y   (112),
    .PADDLE_W   (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .go          (go),
    .x           (x),
    .y           (y),
    .h_q         (h_q),
    .v_q         (v_q),
    .paddle_x    (paddle_x),
    .reset_counts(reset_counts),
    .en_counters (en_counters),
    .sel_c       (sel_c),
    .h_t         (h_t),
    .v_t         (v_t),
    .plot        (plot),
    .off_x       (off_x),
    .off_y       (off_y),
    .lost        (lost)
  );

  // Bit order: rc en sel ht vt plot ox[1:0] oy[1:0] lost
  function automatic logic [10:0] pk(input logic rc, input logic en, input logic sel,
                                     input logic ht, input logic vt, input logic pl,
                                     input logic [1:0] ox, input logic [1:0] oy,
                                     input logic ls);
    return {rc, en, sel, ht, vt, pl, ox, oy, ls};
  endfunction

  always @(negedge clock) begin
    exp_t e;
    logic [10:0] act;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      act = {reset_counts, en_counters, sel_c, h_t, v_t, plot, off_x, off_y, lost};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got rc/en/sel/ht/vt/plot/ox/oy/lost=%b expected %b", e.n, act, e.v);
      end
    end
  end

  task automatic step(input logic [10:0] v, input string n);
    exp_t e;
    @(posedge clock);
    #1;
    e.v = v;
    e.n = n;
    exp_q.push_back(e);
  endtask

  task automatic set_ball(input logic [7:0] bx, input logic [6:0] by,
                          input logic bh, input logic bv);
    x   = bx;
    y   = by;
    h_q = bh;
    v_q = bv;
  endtask

  // Issue go from IDLE and expect one full frame ending in CHECK and MOVE/IDLE.
  task automatic run_frame(input logic ht, input logic vt, input logic ls, input string tag);
    logic [3:0] pc;
    go = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      pc = 4'(i);
      step(pk(1, 0, 1, 0, 0, 1, pc[1:0], pc[3:2], 0), {tag, "_draw"});
      go = 1'b0;
    end
    for (int unsigned i = 0; i < 4; i++) step(pk(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0), {tag, "_wait"});
    for (int unsigned i = 0; i < 16; i++) begin
      pc = 4'(i);
      step(pk(1, 0, 0, 0, 0, 1, pc[1:0], pc[3:2], 0), {tag, "_erase"});
    end
    step(pk(1, 0, 0, ht, vt, 0, 2'd0, 2'd0, ls), {tag, "_check"});
    if (ls) step(pk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0), {tag, "_idle_after_loss"});
    else    step(pk(1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0), {tag, "_move"});
  endtask

  // Continue into the next DRAW, assert reset at p=7 and expect IDLE next cycle.
  task automatic reset_mid_draw(input string tag);
    logic [3:0] pc;
    for (int unsigned i = 0; i < 8; i++) begin
      pc = 4'(i);
      step(pk(1, 0, 1, 0, 0, 1, pc[1:0], pc[3:2], 0), {tag, "_redraw"});
    end
    reset = 1'b1;
    step(pk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0), {tag, "_reset_idle"});
    reset = 1'b0;
    step(pk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0), {tag, "_idle_hold"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    go       = 1'b0;
    paddle_x = 8'd40;
    set_ball(8'd80, 7'd60, 1'b1, 1'b1);

    step(pk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0), "reset0");
    step(pk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0), "reset1");
    reset = 1'b0;
    for (int unsigned i = 0; i < 3; i++) step(pk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0), "idle_no_go");

    set_ball(8'd156, 7'd50, 1'b1, 1'b0);
    run_frame(1, 0, 0, "right_wall");
    reset_mid_draw("right_wall");

    set_ball(8'd0, 7'd0, 1'b0, 1'b0);
    run_frame(1, 1, 0, "corner");
    reset_mid_draw("corner");

    set_ball(8'd80, 7'd60, 1'b1, 1'b1);
    run_frame(0, 0, 0, "open_field");
    reset_mid_draw("open_field");

    set_ball(8'd50, 7'd108, 1'b1, 1'b1);
`ifdef BALL_PADDLE_EN
    run_frame(0, 1, 0, "paddle_hit");
`else
    run_frame(0, 0, 0, "above_bottom");
`endif
    reset_mid_draw("paddle_row");

    set_ball(8'd100, 7'd116, 1'b1, 1'b1);
`ifdef BALL_PADDLE_EN
    run_frame(0, 0, 1, "ball_lost");
    step(pk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0), "lost_stays_idle");
`else
    run_frame(0, 1, 0, "bottom_wall");
    reset_mid_draw("bottom_wall");
`endif

    for (int unsigned i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ball_control.md
# ball_control

Control FSM that sequences the ball animation loop for the play field. It drives the ball datapath's counter reset, counter enable, colour select and direction-toggle inputs, and emits the plot strobe and 4×4 pixel offsets consumed by the VGA adapter. It reads back the datapath's current top-left coordinate and direction flags to detect wall and paddle collisions. The block sits directly upstream of the ball datapath.

## Interface
Parameters:
- FRAME_TICKS, 833333: clock cycles spent in WAIT per frame (60 Hz at 50 MHz); minimum 1.
- X_MAX, 156: rightmost legal top-left x (160 − ball size 4).
- Y_MIN, 0: topmost legal top-left y.
- Y_MAX, 116: bottommost legal top-left y (120 − 4).
- PADDLE_Y, 112: y of the paddle's top row.
- PADDLE_W, 16: paddle width in pixels.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- go  in  1  start request; sampled only in IDLE.
- x  in  8  ball top-left x from the datapath.
- y  in  7  ball top-left y from the datapath.
- h_q  in  1  horizontal direction (1 = +x).
- v_q  in  1  vertical direction (1 = +y).
- paddle_x  in  8  paddle left x.
- reset_counts  out  1  active-low datapath reset; low in IDLE.
- en_counters  out  1  datapath x/y counter enable.
- sel_c  out  1  1 = ball colour, 0 = background.
- h_t  out  1  horizontal direction toggle.
- v_t  out  1  vertical direction toggle.
- plot  out  1  pixel write strobe.
- off_x  out  2  pixel column offset within the ball.
- off_y  out  2  pixel row offset within the ball.
- lost  out  1  one-cycle pulse when the ball leaves past the bottom edge.

## Operation
- States: IDLE, DRAW, WAIT, ERASE, CHECK, MOVE.
- IDLE: reset_counts=0 and all other outputs 0. go=1 → DRAW.
- DRAW: 4-bit pixel counter p runs 0..15. Outputs: plot=1, sel_c=1, off_x=p[1:0], off_y=p[3:2]. At p=15 → WAIT, and p clears.
- WAIT: frame counter runs 0..FRAME_TICKS−1. All outputs 0 except reset_counts=1. At the last count → ERASE.
- ERASE: identical to DRAW except sel_c=0. At p=15 → CHECK.
- CHECK: one cycle. Toggle and loss logic:
  - h_t = (h_q & x≥X_MAX) | (~h_q & x==0).
  - v_t = (~v_q & y≤Y_MIN) | bottom_hit.
  - If a loss is detected: lost=1, h_t=v_t=0, next state IDLE. Otherwise next state MOVE.
- MOVE: en_counters=1 for one cycle → DRAW.
- reset_counts=1 in every state except IDLE.
- Arithmetic uses 9-bit zero-extended intermediates, so x+PADDLE_W does not wrap.
- go is ignored outside IDLE.

## Timing
- Outputs are Moore-decoded from the state register and counters, except h_t/v_t/lost, which are combinational in CHECK from the current inputs.
- The direction flips on the CHECK→MOVE edge. MOVE then steps the counters in the new direction, so a ball at x=156 with h_q=1 moves to x=155.
- One frame takes 16 + FRAME_TICKS + 16 + 1 + 1 cycles.
- reset in any state: next edge enters IDLE, p and the frame counter clear, and all strobes go low in that same cycle.
- Simultaneous corner hit: h_t and v_t are both 1 in the same CHECK cycle.

## Configuration
- BALL_PADDLE_EN defined:
  - bottom_hit = v_q & (y+4==PADDLE_Y) & (x+3 ≥ paddle_x) & (x ≤ paddle_x+PADDLE_W−1).
  - Loss = v_q & y≥Y_MAX.
- BALL_PADDLE_EN undefined:
  - bottom_hit = v_q & y≥Y_MAX (the bottom wall bounces).
  - lost is tied to 0, and paddle_x is unused.

## Structure
- Package ball_pkg holds: the state enum (3-bit encoding), BALL_SIZE=4, SCREEN_W=160, SCREEN_H=120.
- Sub-module ball_frame_timer: a counter with parameter FRAME_TICKS, inputs clock/reset/start, output done.

## Test plan
- reset for 2 cycles, go=0 → state IDLE, reset_counts=0, plot=0 indefinitely.
- FRAME_TICKS=4, go pulse → 16 plot cycles with sel_c=1 and offsets (0,0)…(3,3) row-major; 4 WAIT cycles; 16 plot cycles with sel_c=0; CHECK; one en_counters cycle.
- x=156, h_q=1, y=50, v_q=0 → h_t=1 and v_t=0 in the CHECK cycle; then MOVE.
- x=0, y=0, h_q=0, v_q=0 → h_t=1 and v_t=1 in the same CHECK cycle.
- BALL_PADDLE_EN, paddle_x=40, y=108, v_q=1: x=50 → v_t=1. Same setup with x=100 and y=116 → lost=1, v_t=0, next state IDLE.
- reset asserted at DRAW p=7 → next cycle IDLE, plot=0. A later go restarts at p=0.
